// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-cache port arbiter.
//   - bus widths of the single dcache port
//   - arbiter FSM state encoding
//   - dmem_req_t: latched request payload presented on the dcache port
package dmem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE       = 2'd0;
    localparam arb_state_t ARB_STORE_WAIT = 2'd1;
    localparam arb_state_t ARB_LOAD_WAIT  = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
    } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Single dcache port between the arbiter (master) and the data cache (slave).
//   addr/rmask/wmask/wdata : request, held stable until resp
//   rdata/resp             : cache response, resp is a one-cycle pulse
interface dmem_port_arbiter_if;
    import dmem_port_arbiter_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    modport master (output addr, rmask, wmask, wdata, input rdata, resp);
    modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single dcache port between store-queue commits and loads.
// Stores win in IDLE unless a waiting load has seen LOAD_STARVE_LIMIT store
// grants in a row, in which case dmem_stall holds the SQ off for the load.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   flush_by_branch                  kills in-flight/new loads, never stores
//   store_req/addr/wdata/wmask/idx   SQ head commit request
//   load_req/addr/rmask/tag          load request; load_grant acknowledges
//   dmem_stall                       port busy (or reserved for a load)
//   dmem                             dcache port (master side)
//   load_resp_valid/data/tag         load completion
//   store_done, dcache_store_idx     store completion
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STORE_QUEUE_PTR_WIDTH = 3,
    parameter int unsigned MEM_QUEUE_PTR_WIDTH   = 3,
    parameter int unsigned LOAD_STARVE_LIMIT     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_by_branch,
    input  logic                             store_req,
    input  logic [ADDR_W-1:0]                store_addr,
    input  logic [DATA_W-1:0]                store_wdata,
    input  logic [MASK_W-1:0]                store_wmask,
    input  logic [STORE_QUEUE_PTR_WIDTH-1:0] store_idx,
    input  logic                             load_req,
    input  logic [ADDR_W-1:0]                load_addr,
    input  logic [MASK_W-1:0]                load_rmask,
    input  logic [MEM_QUEUE_PTR_WIDTH-1:0]   load_tag,
    output logic                             load_grant,
    output logic                             dmem_stall,
    dmem_port_arbiter_if.master              dmem,
    output logic                             load_resp_valid,
    output logic [DATA_W-1:0]                load_resp_data,
    output logic [MEM_QUEUE_PTR_WIDTH-1:0]   load_resp_tag,
    output logic                             store_done,
    output logic [STORE_QUEUE_PTR_WIDTH-1:0] dcache_store_idx
);

    localparam int unsigned CNT_W = $clog2(LOAD_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(LOAD_STARVE_LIMIT);

    arb_state_t                       state;
    arb_state_t                       state_next;
    dmem_req_t                        req_q;
    logic [STORE_QUEUE_PTR_WIDTH-1:0] idx_q;
    logic [MEM_QUEUE_PTR_WIDTH-1:0]   tag_q;
    logic [CNT_W-1:0]                 starve_cnt;
    logic                             killed_q;
    logic                             load_starved;
    logic                             store_grant;

    // Independent of store_req: the SQ builds store_req from dmem_stall.
    assign load_starved = load_req && (starve_cnt >= STARVE_MAX) && !flush_by_branch;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grants and completion strobes
    always_comb begin
        state_next      = state;
        dmem_stall      = 1'b1;
        store_grant     = 1'b0;
        load_grant      = 1'b0;
        store_done      = 1'b0;
        load_resp_valid = 1'b0;
        case (state)
            ARB_IDLE: begin
                dmem_stall = load_starved;
                if (store_req && !load_starved) begin
                    store_grant = 1'b1;
                    state_next  = ARB_STORE_WAIT;
                end else if (load_req && !flush_by_branch) begin
                    load_grant = 1'b1;
                    state_next = ARB_LOAD_WAIT;
                end
            end
            ARB_STORE_WAIT: begin
                if (dmem.resp) begin
                    store_done = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            ARB_LOAD_WAIT: begin
                if (dmem.resp) begin
                    // A flush arriving with the response kills it as well.
                    load_resp_valid = !killed_q && !flush_by_branch;
                    state_next      = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Latched request, completion tags, starvation counter and load kill flag
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            starve_cnt <= '0;
            killed_q   <= 1'b0;
        end else begin
            if (store_grant) begin
                req_q <= '{addr: store_addr, wdata: store_wdata, rmask: '0, wmask: store_wmask};
                idx_q <= store_idx;
                if (load_req && (starve_cnt < STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else if (load_grant) begin
                req_q      <= '{addr: load_addr, wdata: '0, rmask: load_rmask, wmask: '0};
                tag_q      <= load_tag;
                starve_cnt <= '0;
            end else if ((state != ARB_IDLE) && dmem.resp) begin
                req_q.rmask <= '0;
                req_q.wmask <= '0;
            end

            if (state == ARB_LOAD_WAIT) begin
                killed_q <= dmem.resp ? 1'b0 : (killed_q || flush_by_branch);
            end else begin
                killed_q <= 1'b0;
            end
        end
    end

    assign dmem.addr  = req_q.addr;
    assign dmem.wdata = req_q.wdata;
    assign dmem.rmask = req_q.rmask;
    assign dmem.wmask = req_q.wmask;

    assign load_resp_data   = load_resp_valid ? dmem.rdata : '0;
    assign load_resp_tag    = load_resp_valid ? tag_q : '0;
    assign dcache_store_idx = store_done ? idx_q : '0;

endmodule
